// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: output-port scheduler for one NoC router output.
// It performs round-robin arbitration among NUM_PORTS inputs, and once a
// packet's head flit wins, it keeps the output for that packet (wormhole lock).
// A credit counter tracks free slots downstream. A flit is sent only while a
// credit is available, so the downstream FIFO cannot overflow.
module noc_output_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 16,
  parameter int CREDITS   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*FLIT_W-1:0] flit_i,
  output logic [NUM_PORTS-1:0]        shift_o,
  output logic [FLIT_W-1:0]           data_o,
  output logic                        valid_o,
  input  logic                        credit_i,
  output logic [2:0]                  credits_o,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic                        err_o
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [PW-1:0] owner;
  logic [PW-1:0] rr_ptr;
  logic [2:0]    credits;

  logic [NUM_PORTS-1:0][FLIT_W-1:0] flits;
  logic [NUM_PORTS-1:0]             head, tail, cand;
  logic [PW-1:0]                    win, sel;
  logic                             win_vld, send, err_next;
  logic [2:0]                       cred_next;

  assign flits = flit_i;

  // Per-port decode of the head and tail flag bits.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign head[g] = flits[g][FLIT_W-1];
    assign tail[g] = flits[g][FLIT_W-2];
  end

  // Round-robin pick among head-flit requesters. The search starts just after
  // rr_ptr. The loop runs downward so that the nearest candidate is assigned last.
  always_comb begin
    cand    = req_i & head;
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      if (cand[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        win_vld = 1'b1;
        win     = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  // Send decision, pop strobe, protocol-error detection and the next credit count.
  always_comb begin
    sel      = (state == IDLE) ? win : owner;
    send     = 1'b0;
    err_next = 1'b0;
    if (state == IDLE) begin
      send     = win_vld && (credits != 3'd0);
      err_next = |(req_i & ~head);
    end else begin
      send     = req_i[owner] && !head[owner] && (credits != 3'd0);
      err_next = req_i[owner] && head[owner];
    end
    if (rst) send = 1'b0;
    shift_o = send ? (NUM_PORTS'(1) << sel) : '0;
    if (credit_i && !send && credits == CRED_MAX) begin
      cred_next = credits;
      err_next  = 1'b1;
    end else begin
      cred_next = credits - 3'(send) + 3'(credit_i);
    end
  end

  assign credits_o = credits;

  // Lock/unlock FSM, registered flit output and credit bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= PW'(NUM_PORTS - 1);
      credits <= CRED_MAX;
      data_o  <= '0;
      valid_o <= 1'b0;
      grant_o <= '0;
      err_o   <= 1'b0;
    end else begin
      valid_o <= send;
      if (send) data_o <= flits[sel];
      credits <= cred_next;
      err_o   <= err_next;
      case (state)
        IDLE: if (send) begin
          if (tail[sel]) begin
            rr_ptr <= sel;
          end else begin
            state   <= LOCKED;
            owner   <= sel;
            grant_o <= NUM_PORTS'(1) << sel;
          end
        end
        LOCKED: if (send && tail[owner]) begin
          state   <= IDLE;
          rr_ptr  <= owner;
          grant_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
